// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter in front of the shared data memory.
// Each access takes three cycles: grant (IDLE), memory access (SERVE), ack (DONE).
// Out-of-range addresses are completed with core_err and never reach the memory.
module data_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_write,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [DATA_W-1:0]           core_rdata,
  output logic                        core_err,
  output logic [2:0]                  grant_id,
  output logic                        busy,
  output logic                        mem_write,
  output logic                        mem_read,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_in,
  input  logic [DATA_W-1:0]           mem_data_out
);

  // state | meaning
  // IDLE  | waiting for requests, picks next requester after last_grant
  // SERVE | drives memory pins for the latched access (one cycle)
  // DONE  | ack/err/rdata presented to the granted core (one cycle)
  typedef enum logic [1:0] {IDLE, SERVE, DONE} state_e;

  localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [2:0]            last_q, last_d;
  logic [2:0]            idx_q, idx_d;
  logic                  we_q, we_d;
  logic                  inr_q, inr_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [NUM_CORES-1:0]  ack_q, ack_d;
  logic                  err_q, err_d;

  logic                  sel_found;
  logic [2:0]            sel_idx;
  logic                  sel_we;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;

  // Round-robin search starting one past the last granted core
  always_comb begin
    int c;
    c         = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int off = 1; off <= NUM_CORES; off++) begin
      c = (int'(last_q) + off) % NUM_CORES;
      if (!sel_found && core_req[c]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(c);
        sel_we    = core_write[c];
        sel_addr  = core_addr[c*ADDR_W +: ADDR_W];
        sel_wdata = core_wdata[c*DATA_W +: DATA_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = SERVE;
      SERVE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: latch on grant, build ack/err/rdata at end of SERVE
  always_comb begin
    last_d  = last_q;
    idx_d   = idx_q;
    we_d    = we_q;
    inr_d   = inr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack_d   = '0;
    err_d   = 1'b0;
    if (state_q == IDLE && sel_found) begin
      last_d  = sel_idx;
      idx_d   = sel_idx;
      we_d    = sel_we;
      inr_d   = (sel_addr < DEPTH_C);
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
    end
    if (state_q == SERVE) begin
      ack_d   = NUM_CORES'(1) << idx_q;
      err_d   = ~inr_q;
      rdata_d = (~we_q & inr_q) ? mem_data_out : '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 3'(NUM_CORES - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      inr_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      inr_q   <= inr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Outputs; memory strobes decode the state so reset drops them at once
  always_comb begin
    busy        = (state_q != IDLE);
    grant_id    = idx_q;
    mem_write   = (state_q == SERVE) & we_q & inr_q;
    mem_read    = (state_q == SERVE) & ~we_q & inr_q;
    mem_address = addr_q;
    mem_data_in = wdata_q;
    core_ack    = ack_q;
    core_err    = err_q;
    core_rdata  = rdata_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter with a behavioural 1000x16 memory.
module tb_data_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    core_req, core_write;
  logic [AW-1:0]   a_addr  [N];
  logic [DW-1:0]   a_wdata [N];
  logic [N*AW-1:0] core_addr;
  logic [N*DW-1:0] core_wdata;
  logic [N-1:0]    core_ack;
  logic [DW-1:0]   core_rdata;
  logic            core_err;
  logic [2:0]      grant_id;
  logic            busy, mem_write, mem_read;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_data_in, mem_data_out;

  logic [DW-1:0]   mem [0:999];
  logic            pre_we;
  logic [AW-1:0]   pre_addr;
  logic [DW-1:0]   pre_data;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int ack_seen = 0;
  int wr_seen = 0;
  int t0;

  typedef struct {
    logic [N-1:0]  ack;
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign core_addr[g*AW +: AW]  = a_addr[g];
    assign core_wdata[g*DW +: DW] = a_wdata[g];
  end

  data_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(1000)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_write(core_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata), .core_err(core_err),
    .grant_id(grant_id), .busy(busy),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign mem_data_out = (mem_address < 16'd1000) ? mem[mem_address[9:0]] : '0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_addr[9:0]] <= pre_data;
    else if (mem_write && mem_address < 16'd1000) mem[mem_address[9:0]] <= mem_data_in;
  end

  // Scoreboard: every ack pops one expectation
  always @(negedge clk) begin
    if (mem_write === 1'b1) wr_seen++;
    if (core_ack !== '0) begin
      ack_seen++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: got ack=%b at cycle %0d, required no ack", core_ack, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (core_ack !== mon_e.ack || core_rdata !== mon_e.rdata || core_err !== mon_e.err ||
            busy !== 1'b1 || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL ack_scoreboard: got ack=%b rdata=%h err=%b busy=%b cycle=%0d, required ack=%b rdata=%h err=%b busy=1 cycle=%0d",
                   core_ack, core_rdata, core_err, busy, cyc, mon_e.ack, mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  task automatic push(input logic [N-1:0] ack, input logic [DW-1:0] rd, input logic err, input int c);
    sb.push_back('{ack, rd, err, c});
  endtask

  task automatic start(input int core, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    a_addr[core]     = addr;
    a_wdata[core]    = wd;
    core_write[core] = wr;
    core_req[core]   = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] d);
    pre_addr = addr;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk); #1;
    pre_we   = 1'b0;
  endtask

  task automatic do_reset();
    core_req = '0;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Runs until n acks were seen; drops req of cores in 'drop' on their ack, all on the last
  task automatic service(input logic [N-1:0] drop, input int n, input int budget);
    int got;
    got = 0;
    for (int t = 0; t < budget && got < n; t++) begin
      @(negedge clk);
      if (core_ack !== '0) begin
        got++;
        for (int i = 0; i < N; i++) if (core_ack[i] && drop[i]) core_req[i] = 1'b0;
        if (got == n) core_req = '0;
      end
    end
    checks++;
    if (got != n) begin
      failures++;
      core_req = '0;
      $display("FAIL service_timeout: got %0d acks, required %0d", got, n);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain: got %0d pending expectations busy=%b, required 0 pending busy=0", sb.size(), busy);
    end
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (core_ack !== '0 || core_rdata !== '0 || core_err !== 1'b0 || grant_id !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got ack=%b rdata=%h err=%b gid=%0d busy=%b, required all 0",
               core_ack, core_rdata, core_err, grant_id, busy);
    end
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_address !== '0 || mem_data_in !== '0) begin
      failures++;
      $display("FAIL reset_mem_pins: got we=%b re=%b addr=%h din=%h, required all 0",
               mem_write, mem_read, mem_address, mem_data_in);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: got busy=%b, required 0", busy);
    end
  endtask

  task automatic test_store_load();
    start(1, 1'b1, 16'd5, 16'h00AB);
    t0 = cyc;
    push(4'b0010, 16'h0000, 1'b0, t0 + 2);
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 16'd5 || mem_data_in !== 16'h00AB) begin
      failures++;
      $display("FAIL store_serve: got we=%b re=%b addr=%h din=%h, required we=1 re=0 addr=0005 din=00ab",
               mem_write, mem_read, mem_address, mem_data_in);
    end
    checks++;
    if (grant_id !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL store_grant: got gid=%0d busy=%b, required gid=1 busy=1", grant_id, busy);
    end
    service(4'b1111, 1, 20);
    start(1, 1'b0, 16'd5, 16'h0000);
    t0 = cyc;
    push(4'b0010, 16'h00AB, 1'b0, t0 + 2);
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
      failures++;
      $display("FAIL load_serve: got re=%b we=%b, required re=1 we=0", mem_read, mem_write);
    end
    service(4'b1111, 1, 20);
  endtask

  task automatic test_all_cores();
    for (int i = 0; i < N; i++) preload(16'(100 + i), 16'(16'h1000 + i));
    do_reset();
    for (int i = 0; i < N; i++) start(i, 1'b0, 16'(100 + i), 16'h0000);
    t0 = cyc;
    for (int i = 0; i < N; i++) push(4'(1 << i), 16'(16'h1000 + i), 1'b0, t0 + 2 + 3 * i);
    service(4'b1111, 4, 40);
  endtask

  task automatic test_back_to_back();
    preload(16'd200, 16'h0200);
    preload(16'd202, 16'h0202);
    do_reset();
    start(0, 1'b0, 16'd200, 16'h0000);
    start(2, 1'b0, 16'd202, 16'h0000);
    t0 = cyc;
    push(4'b0001, 16'h0200, 1'b0, t0 + 2);
    push(4'b0100, 16'h0202, 1'b0, t0 + 5);
    push(4'b0001, 16'h0200, 1'b0, t0 + 8);
    push(4'b0100, 16'h0202, 1'b0, t0 + 11);
    service(4'b0000, 4, 40);
  endtask

  task automatic test_out_of_range();
    int w0;
    preload(16'd999, 16'h5A5A);
    w0 = wr_seen;
    start(3, 1'b1, 16'd1000, 16'h1234);
    t0 = cyc;
    push(4'b1000, 16'h0000, 1'b1, t0 + 2);
    service(4'b1111, 1, 20);
    checks++;
    if (wr_seen != w0) begin
      failures++;
      $display("FAIL oor_no_write: got %0d write cycles, required 0", wr_seen - w0);
    end
    start(3, 1'b0, 16'd999, 16'h0000);
    t0 = cyc;
    push(4'b1000, 16'h5A5A, 1'b0, t0 + 2);
    service(4'b1111, 1, 20);
  endtask

  task automatic test_reset_mid_serve();
    int a0;
    preload(16'd20, 16'h0F0F);
    do_reset();
    a0 = ack_seen;
    start(0, 1'b1, 16'd20, 16'hBEEF);
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_write !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_write: got we=%b, required 1", mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_drop: got we=%b busy=%b, required we=0 busy=0", mem_write, busy);
    end
    core_req = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack_seen != a0 || mem[20] !== 16'h0F0F) begin
      failures++;
      $display("FAIL rst_no_effect: got acks=%0d mem20=%h, required acks=0 mem20=0f0f", ack_seen - a0, mem[20]);
    end
    start(0, 1'b1, 16'd20, 16'hBEEF);
    t0 = cyc;
    push(4'b0001, 16'h0000, 1'b0, t0 + 2);
    service(4'b1111, 1, 20);
    checks++;
    if (mem[20] !== 16'hBEEF) begin
      failures++;
      $display("FAIL rst_retry_write: got mem20=%h, required beef", mem[20]);
    end
  endtask

  task automatic test_rr_mixed();
    preload(16'd998, 16'd9);
    do_reset();
    start(2, 1'b0, 16'd998, 16'h0000);
    start(1, 1'b1, 16'd10, 16'h0077);
    t0 = cyc;
    push(4'b0010, 16'h0000, 1'b0, t0 + 2);
    push(4'b0100, 16'd9, 1'b0, t0 + 5);
    service(4'b1111, 2, 30);
    checks++;
    if (mem[10] !== 16'h0077) begin
      failures++;
      $display("FAIL rr_store: got mem10=%h, required 0077", mem[10]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish by 200000, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    core_req   = '0;
    core_write = '0;
    pre_we     = 1'b0;
    pre_addr   = '0;
    pre_data   = '0;
    for (int i = 0; i < N; i++) begin
      a_addr[i]  = '0;
      a_wdata[i] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_all_cores();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_serve();
    test_rr_mixed();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
